// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH+1 cycles from accepted start to a one-cycle done; start is ignored while busy.
// Optional signed-overflow output ovf, enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  assign fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign res_d = {fa_s, res_q[WIDTH-1:1]};
`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit the operand LSBs are the original MSBs.
  assign ovf_d = (a_q[0] == b_q[0]) && (fa_s != a_q[0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            sum_q   <= res_d;
            cout_q  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on rising clk.
REQ-006 a  input  WIDTH  addend A; captured when start is accepted.
REQ-007 b  input  WIDTH  addend B; captured when start is accepted.
REQ-008 cin  input  1  carry-in; captured when start is accepted.
REQ-009 busy  output  1  high while the operation is in progress.
REQ-010 done  output  1  single-cycle pulse; sum and cout are valid.
REQ-011 sum  output  WIDTH  registered result, A+B+cin mod 2^WIDTH.
REQ-012 cout  output  1  registered carry-out of the MSB.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE or DONE with start=1: accept; capture a, b, cin into internal shift registers; clear the bit counter; go to SHIFT.
REQ-015 IDLE with start=0: remain in IDLE. DONE with start=0: go to IDLE.
REQ-016 SHIFT: each cycle, one full-adder on the operand LSBs and the carry flop; sum bit shifts into the MSB of the result register; operands shift right; carry flop updates; counter increments.
REQ-017 SHIFT exits to DONE after exactly WIDTH bit cycles.
REQ-018 DONE lasts one cycle: done=1; sum holds the full result; cout holds the final carry.
REQ-019 Latency: start accepted at edge N gives done=1 during the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles from start to done.
REQ-020 busy=1 exactly in SHIFT; done=1 exactly in DONE; never both.
REQ-021 start while busy=1 is ignored; no recapture and no effect on the current result.
REQ-022 start during DONE is accepted; done pulses this cycle and SHIFT begins next cycle, so back-to-back operations lose no cycle.
REQ-023 sum and cout keep the last completed result until the next completion; they are not updated while in SHIFT.
REQ-024 Changes on a, b, cin after acceptance do not affect the result in progress.
REQ-025 Boundary: all-ones + all-ones + 1 gives sum=all-ones, cout=1; all-zeros + all-zeros + 0 gives sum=0, cout=0.

Reset
REQ-026 rst_n low asynchronously forces state IDLE; busy=0, done=0, sum=0, cout=0; clears counter, carry and operand registers.
REQ-027 Reset during SHIFT aborts the operation; no done pulse follows release.
REQ-028 After rst_n deassertion, the first accepted start behaves as in REQ-014 and REQ-019.

Configuration
REQ-029 Macro SERIAL_ADDER_OVF_EN defined: add output port ovf (1 bit), registered with sum; ovf=1 when A[MSB]==B[MSB] and sum[MSB]!=A[MSB] (two's-complement signed overflow); ovf reset value 0; ovf held like sum.
REQ-030 Macro SERIAL_ADDER_OVF_EN undefined: port ovf and its logic are absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=8, a=8'h05, b=8'h03, cin=0, start pulse at cycle 0 -> busy cycles 1-8, done cycle 9, sum=8'h08, cout=0.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-033 With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1; a=8'h80, b=8'hFF -> sum=8'h7F, cout=1, ovf=1.
REQ-034 Start 8'h10+8'h20; assert start with a=8'hAA at cycle 4 -> ignored; done at cycle 9 with sum=8'h30.
REQ-035 Start held high during DONE with a=8'h01, b=8'h01 -> first done shows the prior result; second done exactly 9 cycles later with sum=8'h02.
REQ-036 rst_n pulsed low at cycle 5 of an operation -> outputs 0 immediately, no done pulse; the next operation completes normally.
